// File: rtl/decode_execute_stage_if.sv
// decode_execute_stage_if: decode inputs, forwarding sources and the D->E register outputs
interface decode_execute_stage_if #(parameter int DATA_WID = 64, parameter int ADDR_WID = 4);
  logic [3:0]          D_icode, D_ifun;
  logic [2:0]          D_stat;
  logic [DATA_WID-1:0] D_valC, D_valP;
  logic [ADDR_WID-1:0] d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_WID-1:0] d_rvalA, d_rvalB;
  logic [ADDR_WID-1:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [DATA_WID-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic                e_Cnd, E_stall, E_bubble;
  logic                load_use, mispredict;
  logic [3:0]          E_icode, E_ifun;
  logic [2:0]          E_stat;
  logic [DATA_WID-1:0] E_valC, E_valA, E_valB;
  logic [ADDR_WID-1:0] E_srcA, E_srcB, E_dstE, E_dstM;
  modport master (
    output D_icode, D_ifun, D_stat, D_valC, D_valP, d_srcA, d_srcB, d_dstE, d_dstM,
           d_rvalA, d_rvalB, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM, e_Cnd, E_stall, E_bubble,
    input  load_use, mispredict, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
           E_srcA, E_srcB, E_dstE, E_dstM
  );
  modport slave (
    input  D_icode, D_ifun, D_stat, D_valC, D_valP, d_srcA, d_srcB, d_dstE, d_dstM,
           d_rvalA, d_rvalB, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM, e_Cnd, E_stall, E_bubble,
    output load_use, mispredict, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
           E_srcA, E_srcB, E_dstE, E_dstM
  );
endinterface

// File: rtl/decode_execute_stage.sv
// decode_execute_stage: operand forwarding, load/use and mispredict detection, D->E register
module decode_execute_stage #(
  parameter int DATA_WID = 64,
  parameter int ADDR_WID = 4
) (
  input logic CLK,
  input logic RST_N,
  decode_execute_stage_if.slave bus
);
  localparam logic [ADDR_WID-1:0] NonReg = '1;
  localparam logic [3:0] Nop = 4'h1, Mrmovq = 4'h5, Jxx = 4'h7, Call = 4'h8, Popq = 4'hB;
  typedef struct packed {
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [2:0]          stat;
    logic [DATA_WID-1:0] valC;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;
    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [ADDR_WID-1:0] dstE;
    logic [ADDR_WID-1:0] dstM;
  } eRegT;
  localparam eRegT Bubble = '{icode: Nop, ifun: 4'h0, stat: 3'h1, valC: '0, valA: '0, valB: '0,
                              srcA: NonReg, srcB: NonReg, dstE: NonReg, dstM: NonReg};
  eRegT eReg, dIn;
  logic [DATA_WID-1:0] fwdA, fwdB;
  logic loadE;
  // NonReg sources never match, so "no register" is never forwarded
  function automatic logic hit(input logic [ADDR_WID-1:0] src, input logic [ADDR_WID-1:0] dst);
    return src != NonReg && src == dst;
  endfunction
  // forwarding chains: youngest producer first; CALL/JXX carry valP in valA
  always_comb begin
    fwdA = (bus.D_icode == Call || bus.D_icode == Jxx) ? bus.D_valP :
           hit(bus.d_srcA, bus.e_dstE) ? bus.e_valE :
           hit(bus.d_srcA, bus.M_dstM) ? bus.m_valM :
           hit(bus.d_srcA, bus.M_dstE) ? bus.M_valE :
           hit(bus.d_srcA, bus.W_dstM) ? bus.W_valM :
           hit(bus.d_srcA, bus.W_dstE) ? bus.W_valE : bus.d_rvalA;
    fwdB = hit(bus.d_srcB, bus.e_dstE) ? bus.e_valE :
           hit(bus.d_srcB, bus.M_dstM) ? bus.m_valM :
           hit(bus.d_srcB, bus.M_dstE) ? bus.M_valE :
           hit(bus.d_srcB, bus.W_dstM) ? bus.W_valM :
           hit(bus.d_srcB, bus.W_dstE) ? bus.W_valE : bus.d_rvalB;
    dIn = '{icode: bus.D_icode, ifun: bus.D_ifun, stat: bus.D_stat, valC: bus.D_valC,
            valA: fwdA, valB: fwdB, srcA: bus.d_srcA, srcB: bus.d_srcB,
            dstE: bus.d_dstE, dstM: bus.d_dstM};
  end
  assign bus.load_use = (eReg.icode == Mrmovq || eReg.icode == Popq) && eReg.dstM != NonReg &&
                        (eReg.dstM == bus.d_srcA || eReg.dstM == bus.d_srcB);
  assign bus.mispredict = eReg.icode == Jxx && !bus.e_Cnd;
  assign loadE = bus.E_bubble || bus.load_use || bus.mispredict;
  // E register: stall holds, any hazard or bubble request inserts a NOP, reset discards everything
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) eReg <= Bubble;
    else if (!bus.E_stall) eReg <= loadE ? Bubble : dIn;
  assign bus.E_icode = eReg.icode;
  assign bus.E_ifun  = eReg.ifun;
  assign bus.E_stat  = eReg.stat;
  assign bus.E_valC  = eReg.valC;
  assign bus.E_valA  = eReg.valA;
  assign bus.E_valB  = eReg.valB;
  assign bus.E_srcA  = eReg.srcA;
  assign bus.E_srcB  = eReg.srcB;
  assign bus.E_dstE  = eReg.dstE;
  assign bus.E_dstM  = eReg.dstM;
endmodule
